// File: rtl/alu_pkg.sv
// Shared ALU types and widths for the multiplier controller and its adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand/product handshake bundle between a producer/consumer and mul_seq_ctrl.
// Latency: none (wiring only).
// Backpressure: valid/ready on both the operand and the product side.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/adder32.sv
// 32-bit unsigned adder with carry in and carry out.
// Latency: combinational.
// Backpressure: not applicable.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        carry
);
    logic [32:0] total;

    assign total        = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    assign {carry, sum} = total;
endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned shift-add multiplier sharing a single adder32.
// Latency: out_valid rises WIDTH+1 edges after the operand accept edge, data-independent.
// Backpressure: in_ready low while busy or holding a result; product held until out_ready.
module mul_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_seq_ctrl_if.slave mif
);
    localparam int CNTW = $clog2(WIDTH);

    mul_state_t         state_q;
    mul_state_t         state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNTW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               ovld_q;

    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;
    logic               last_iter;

    adder32 u_adder32 (
        .a     (hi_q),
        .b     (mcand_q),
        .cin   (1'b0),
        .sum   (sum),
        .carry (carry)
    );

    // The adder carry is the only source for hi's MSB after the shift.
    assign {hi_nxt, lo_nxt} = lo_q[0] ? {carry, sum, lo_q[WIDTH-1:1]}
                                      : {1'b0, hi_q, lo_q[WIDTH-1:1]};

    assign last_iter = (state_q == MUL_BUSY) && (cnt_q == CNTW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (mif.in_valid)              state_d = MUL_BUSY;
            MUL_BUSY: if (last_iter)                 state_d = MUL_DONE;
            MUL_DONE: if (ovld_q && mif.out_ready)   state_d = MUL_IDLE;
            default:                                 state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            ovld_q  <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (mif.in_valid) begin
                        mcand_q <= mif.op_a;
                        hi_q    <= '0;
                        lo_q    <= mif.op_b;
                        cnt_q   <= '0;
                    end
                end
                MUL_BUSY: begin
                    hi_q  <= hi_nxt;
                    lo_q  <= lo_nxt;
                    // Hold at the terminal count; the next accept reloads it.
                    if (!last_iter) begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                MUL_DONE: begin
                    if (!ovld_q) begin
                        prod_q <= {hi_q, lo_q};
                        ovld_q <= 1'b1;
                    end else if (mif.out_ready) begin
                        ovld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mif.in_ready  = (state_q == MUL_IDLE);
    assign mif.busy      = (state_q == MUL_BUSY);
    assign mif.out_valid = ovld_q;
    assign mif.product   = prod_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with an expected-product scoreboard and latency monitor.
module tb_mul_seq_ctrl;

    logic clk;
    logic rst_n;

    mul_seq_ctrl_if #(.WIDTH(32)) bus ();

    mul_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nmis = 0;
    logic [63:0] exp_q[$];
    longint      cyc = 0;
    longint      acc_edge = 0;
    logic        prev_vld = 1'b0;

    localparam longint LAT = 33;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: one compare of product and latency per out_valid rise.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_edge = cyc + 1;
        if (bus.out_valid && !prev_vld) begin
            if (exp_q.size() == 0) begin
                chk64("unexpected_product", bus.product, 64'hx);
            end else begin
                chk64("product", bus.product, exp_q.pop_front());
                chk64("latency", 64'(cyc - acc_edge), 64'(LAT));
            end
        end
        prev_vld = bus.out_valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
        int n;
        @(posedge clk); #1;
        bus.op_a = a;
        bus.op_b = b;
        bus.in_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) chk64("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic finish(input logic [63:0] exp, input int hold);
        int n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk64("done_timeout", {63'd0, bus.out_valid}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk64("hold_product", bus.product, exp);
            chk64("hold_valid_ready", {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk64("post_ack_vld_rdy_busy", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'd2);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        chk64("reset_product", bus.product, 64'd0);
        chk64("reset_vld_rdy_busy", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'd2);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        finish(64'h0000_0000_0000_000F, 0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        finish(64'hFFFF_FFFE_0000_0001, 0);

        issue(32'd0, 32'h1234_5678, 64'd0, 1'b1);
        finish(64'd0, 0);

        issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
        finish(64'h0000_0001_0000_0000, 10);

        // Operands offered while busy must be ignored until the next IDLE.
        issue(32'h11, 32'h22, 64'h242, 1'b1);
        @(posedge clk); #1;
        bus.op_a = 32'hAAAA_AAAA;
        bus.op_b = 32'h5555_5555;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk64("busy_ignores_in", {62'd0, bus.busy, bus.in_ready}, 64'd2);
        end
        @(posedge clk); #1;
        bus.op_a = 32'd100;
        bus.op_b = 32'd3;
        exp_q.push_back(64'd300);
        finish(64'h242, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        finish(64'd300, 0);

        // Reset in the middle of an operation discards it.
        issue(32'd7, 32'd9, 64'd63, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk64("midrst_product", bus.product, 64'd0);
        chk64("midrst_vld_rdy_busy", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd7, 32'd9, 64'd63, 1'b1);
        finish(64'd63, 0);

        repeat (3) @(negedge clk);
        chk64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1);
    end

endmodule
